instr_fetch: RTL and testbench

Instruction-fetch stage sitting between the PC register and the IF/ID pipeline register. It reads the current PC, runs a request/acknowledge handshake with a variable-latency instruction memory, and buffers fetched instructions in a 2-entry queue toward decode. It tells the PC register when to advance (`pc_write_o`) and discards wrong-path fetches on a branch/jump flush.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_buffer.sv | 90 +++++++++
 rtl/instr_fetch.sv | 96 +++++++++
 tb/tb_instr_fetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM state type and default widths/constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Instruction presented to decode while nothing valid is buffered.
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    // IDLE : nothing outstanding
    // REQ  : request outstanding, result wanted
    // DRAIN: request outstanding, result killed by a flush
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, instr} FIFO between fetch and decode, with push, pop and clear.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: caller must not push when full; clear has priority over push/pop.
// Ports: clk_i/rst_i; clear_i, push_i (+push_pc_i/push_dat_i), pop_i in;
//        count_o, head_pc_o, head_dat_o, valid_o out (all registered).
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [DATA_W-1:0] push_dat_i,
    input  logic              pop_i,
    output logic [1:0]        count_o,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [DATA_W-1:0] head_dat_o,
    output logic              valid_o
);

    logic [1:0]        count_q;
    logic [ADDR_W-1:0] head_pc_q, tail_pc_q;
    logic [DATA_W-1:0] head_dat_q, tail_dat_q;
    logic              do_pop;

    assign do_pop = pop_i && (count_q != 2'd0);

    // Head slot is always the oldest entry, so the outputs come straight from
    // registers. An empty head is parked at {0, NOP}.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q    <= 2'd0;
            head_pc_q  <= '0;
            head_dat_q <= NOP_INSTR;
            tail_pc_q  <= '0;
            tail_dat_q <= NOP_INSTR;
        end else if (clear_i) begin
            count_q    <= 2'd0;
            head_pc_q  <= '0;
            head_dat_q <= NOP_INSTR;
        end else begin
            case ({push_i, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_pc_q  <= push_pc_i;
                        head_dat_q <= push_dat_i;
                    end else begin
                        tail_pc_q  <= push_pc_i;
                        tail_dat_q <= push_dat_i;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_pc_q  <= tail_pc_q;
                        head_dat_q <= tail_dat_q;
                    end else begin
                        head_pc_q  <= '0;
                        head_dat_q <= NOP_INSTR;
                    end
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: count unchanged, queue shifts.
                    if (count_q == 2'd2) begin
                        head_pc_q  <= tail_pc_q;
                        head_dat_q <= tail_dat_q;
                        tail_pc_q  <= push_pc_i;
                        tail_dat_q <= push_dat_i;
                    end else begin
                        head_pc_q  <= push_pc_i;
                        head_dat_q <= push_dat_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count_o    = count_q;
    assign head_pc_o  = head_pc_q;
    assign head_dat_o = head_dat_q;
    assign valid_o    = (count_q != 2'd0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: req/ack handshake with variable-latency imem, 2-entry buffer to decode, flush kill.
// Latency: zero-wait memory gives valid one cycle after the request cycle; k waits add k cycles.
// Backpressure: stall_i holds the buffer; new requests stop while the buffer holds 2 entries.
// Ports: clk_i/rst_i; start_i, pc_i, flush_i, stall_i, imem_ack_i, imem_data_i in;
//        pc_write_o, imem_req_o, imem_addr_o (combinational), instr_o, instr_pc_o, instr_valid_o (registered).
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_write_o,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_data_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_valid_o
);

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        buf_count;
    logic              buf_valid;
    logic              issue;
    logic              ack_keep;
    logic              pop;

    // rst_i gates the combinational outputs so a mid-request reset drops
    // imem_req_o immediately even while start_i is still high.
    assign issue = !rst_i && (state_q == ST_IDLE) && start_i && !flush_i
                   && (buf_count < 2'd2);

    assign imem_req_o  = issue || (state_q != ST_IDLE);
    assign imem_addr_o = issue ? pc_i : addr_q;

    // An ack is kept only if its request was not killed earlier (DRAIN)
    // and is not being killed right now (flush_i).
    assign ack_keep   = !rst_i && imem_ack_i && (state_q != ST_DRAIN) && !flush_i;
    assign pc_write_o = ack_keep || (!rst_i && flush_i);

    assign pop = buf_valid && !stall_i && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        addr_q <= pc_i;
                        if (!imem_ack_i) state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (imem_ack_i)   state_q <= ST_IDLE;
                    else if (flush_i) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (imem_ack_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    fetch_buffer #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_fetch_buffer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (flush_i),
        .push_i     (ack_keep),
        .push_pc_i  (imem_addr_o),
        .push_dat_i (imem_data_i),
        .pop_i      (pop),
        .count_o    (buf_count),
        .head_pc_o  (instr_pc_o),
        .head_dat_o (instr_o),
        .valid_o    (buf_valid)
    );

    assign instr_valid_o = buf_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural PC register and wait-state memory around the DUT,
// directed per-cycle checks, and a scoreboard of expected PCs consumed by a monitor.
// Memory returns ~address as the instruction word.
module tb_instr_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] pc_i = 32'h0;
    logic        pc_write_o;
    logic        flush_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;

    instr_fetch dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .pc_i          (pc_i),
        .pc_write_o    (pc_write_o),
        .flush_i       (flush_i),
        .stall_i       (stall_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model: ack after wait_cycles ----------------
    int wait_cycles = 0;
    int busy = 0;
    assign imem_data_i = ~imem_addr_o;

    always @(posedge clk_i) begin
        #2;
        if (imem_req_o && !rst_i) begin
            if (busy == wait_cycles) begin
                imem_ack_i = 1'b1;
                busy = 0;
            end else begin
                imem_ack_i = 1'b0;
                busy++;
            end
        end else begin
            imem_ack_i = 1'b0;
            busy = 0;
        end
    end

    // ---------------- PC register model ----------------
    logic        pcw_s = 1'b0;
    logic        fl_s = 1'b0;
    logic [31:0] target = 32'h0;

    always @(negedge clk_i) begin
        pcw_s = pc_write_o;
        fl_s  = flush_i;
    end

    always @(posedge clk_i) begin
        #1;
        if (pcw_s) pc_i = fl_s ? target : pc_i + 32'd4;
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];

    always @(negedge clk_i) begin
        if (!rst_i && instr_valid_o && !stall_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_instr_pc", instr_pc_o, 32'hxxxx_xxxx);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", instr_pc_o, e);
                chk("sb_instr", instr_o, ~e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_i);
    endtask

    initial begin
        // ---- reset ----
        cyc(); cyc();
        neg();
        chk("rst_req",   {31'b0, imem_req_o}, 32'd0);
        chk("rst_addr",  imem_addr_o, 32'h0);
        chk("rst_pcw",   {31'b0, pc_write_o}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_ipc",   instr_pc_o, 32'h0);
        cyc(); rst_i = 1'b0;
        cyc();

        // ---- zero-wait streaming 0,4,8 ----
        cyc(); start_i = 1'b1; wait_cycles = 0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        neg(); chk("zw_req0", {31'b0, imem_req_o}, 32'd1);
               chk("zw_addr0", imem_addr_o, 32'h0);
               chk("zw_pcw0", {31'b0, pc_write_o}, 32'd1);
        cyc();
        neg(); chk("zw_addr1", imem_addr_o, 32'h4);
               chk("zw_pcw1", {31'b0, pc_write_o}, 32'd1);
               chk("zw_valid1", {31'b0, instr_valid_o}, 32'd1);
        cyc();
        neg(); chk("zw_addr2", imem_addr_o, 32'h8);
        cyc(); start_i = 1'b0;
        neg(); chk("zw_req3", {31'b0, imem_req_o}, 32'd0);
        cyc(); cyc();

        // ---- 2-wait memory at 0x10 ----
        cyc(); pc_i = 32'h10; wait_cycles = 2; start_i = 1'b1;
        exp_q.push_back(32'h10);
        neg(); chk("w2_addr0", imem_addr_o, 32'h10);
               chk("w2_pcw0", {31'b0, pc_write_o}, 32'd0);
        cyc(); start_i = 1'b0;
        neg(); chk("w2_addr1", imem_addr_o, 32'h10);
               chk("w2_req1", {31'b0, imem_req_o}, 32'd1);
               chk("w2_pcw1", {31'b0, pc_write_o}, 32'd0);
        cyc();
        neg(); chk("w2_addr2", imem_addr_o, 32'h10);
               chk("w2_pcw2", {31'b0, pc_write_o}, 32'd1);
        cyc();
        neg(); chk("w2_valid", {31'b0, instr_valid_o}, 32'd1);
               chk("w2_req3", {31'b0, imem_req_o}, 32'd0);
        cyc(); cyc();

        // ---- stall fills buffer to 2 ----
        cyc(); wait_cycles = 0; stall_i = 1'b1; pc_i = 32'h40; start_i = 1'b1;
        exp_q.push_back(32'h40); exp_q.push_back(32'h44);
        neg(); chk("st_req0", {31'b0, imem_req_o}, 32'd1);
        cyc();
        neg(); chk("st_addr1", imem_addr_o, 32'h44);
        cyc();
        neg(); chk("st_req2", {31'b0, imem_req_o}, 32'd0);
               chk("st_ipc2", instr_pc_o, 32'h40);
        cyc();
        neg(); chk("st_req3", {31'b0, imem_req_o}, 32'd0);
               chk("st_ipc3", instr_pc_o, 32'h40);
        cyc(); stall_i = 1'b0;
        neg(); chk("st_req4_full", {31'b0, imem_req_o}, 32'd0);
        cyc(); start_i = 1'b0;
        neg(); chk("st_ipc5", instr_pc_o, 32'h44);
        cyc();
        neg(); chk("st_empty", {31'b0, instr_valid_o}, 32'd0);
        cyc();

        // ---- flush with request to 0x20 outstanding ----
        cyc(); pc_i = 32'h20; wait_cycles = 2; start_i = 1'b1;
        exp_q.push_back(32'h100);
        neg(); chk("fl_addr0", imem_addr_o, 32'h20);
        cyc(); flush_i = 1'b1; target = 32'h100;
        neg(); chk("fl_pcw1", {31'b0, pc_write_o}, 32'd1);
        cyc(); flush_i = 1'b0;
        neg(); chk("fl_drain_req", {31'b0, imem_req_o}, 32'd1);
               chk("fl_drain_addr", imem_addr_o, 32'h20);
               chk("fl_drain_pcw", {31'b0, pc_write_o}, 32'd0);
        cyc();
        neg(); chk("fl_new_addr", imem_addr_o, 32'h100);
               chk("fl_new_req", {31'b0, imem_req_o}, 32'd1);
               chk("fl_valid", {31'b0, instr_valid_o}, 32'd0);
        cyc(); start_i = 1'b0;
        cyc();
        neg(); chk("fl_ack_pcw", {31'b0, pc_write_o}, 32'd1);
        cyc();
        neg(); chk("fl_valid_new", {31'b0, instr_valid_o}, 32'd1);
        cyc(); cyc();

        // ---- flush + stall with 2 entries buffered ----
        cyc(); wait_cycles = 0; stall_i = 1'b1; pc_i = 32'h200; start_i = 1'b1;
        cyc();
        cyc(); flush_i = 1'b1; target = 32'h300;
        neg(); chk("fs_pcw", {31'b0, pc_write_o}, 32'd1);
               chk("fs_full", {31'b0, instr_valid_o}, 32'd1);
        cyc(); flush_i = 1'b0; stall_i = 1'b0; start_i = 1'b0;
        neg(); chk("fs_valid", {31'b0, instr_valid_o}, 32'd0);
               chk("fs_instr", instr_o, 32'h0);
               chk("fs_ipc", instr_pc_o, 32'h0);
        cyc();

        // ---- async reset during REQ ----
        cyc(); wait_cycles = 3; pc_i = 32'h400; start_i = 1'b1;
        neg(); chk("ar_req0", {31'b0, imem_req_o}, 32'd1);
        cyc(); start_i = 1'b1;
        #2; rst_i = 1'b1;
        #1;
        chk("ar_req", {31'b0, imem_req_o}, 32'd0);
        chk("ar_addr", imem_addr_o, 32'h0);
        chk("ar_pcw", {31'b0, pc_write_o}, 32'd0);
        chk("ar_valid", {31'b0, instr_valid_o}, 32'd0);
        chk("ar_instr", instr_o, 32'h0);
        cyc(); start_i = 1'b0;
        cyc(); rst_i = 1'b0;
        cyc();
        neg(); chk("ar_req_after", {31'b0, imem_req_o}, 32'd0);
        cyc();

        chk("sb_leftover", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
